// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin ALU/LSU writeback arbiter with a registered write stage and busy scoreboard.
// Define REG_WB_BYPASS_EN to forward the committing write to rs1/rs2 in the same cycle.
module reg_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
`ifdef REG_WB_BYPASS_EN
    output logic [DATA_W-1:0] rs1_byp_data,
    output logic [DATA_W-1:0] rs2_byp_data,
`endif
    output logic              write_en,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {GNT_ALU = 1'b0, GNT_LSU = 1'b1} grant_e;

    grant_e            last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [NREG-1:0]   busy_q, busy_d, set_vec, clr_vec;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    // ALU wins unless LSU also requests and ALU was granted last; readies are gated off during reset
    always_comb begin
        alu_ready = rst_n && alu_valid && (!lsu_valid || last_q == GNT_LSU);
        lsu_ready = rst_n && lsu_valid && !alu_ready;
        sel_rd    = alu_ready ? alu_rd : lsu_rd;
        sel_data  = alu_ready ? alu_data : lsu_data;
        last_d    = alu_ready ? GNT_ALU : (lsu_ready ? GNT_LSU : last_q);
        we_d      = (alu_ready || lsu_ready) && sel_rd != '0;
        wa_d      = we_d ? sel_rd : wa_q;
        wd_d      = we_d ? sel_data : wd_q;
        set_vec   = (issue_valid && issue_rd != '0) ? (NREG'(1) << issue_rd) : '0;
        clr_vec   = we_q ? (NREG'(1) << wa_q) : '0;
        busy_d    = ((busy_q & ~clr_vec) | set_vec) & ~NREG'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_LSU;
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            busy_q <= '0;
        end else begin
            last_q <= last_d;
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            busy_q <= busy_d;
        end
    end

    assign write_en      = we_q;
    assign write_address = wa_q;
    assign write_data    = wd_q;

`ifdef REG_WB_BYPASS_EN
    logic hit1, hit2;

    // A committing write resolves the hazard now, unless a newer producer of the same register issues
    always_comb begin
        hit1         = we_q && wa_q == rs1_addr && rs1_addr != '0;
        hit2         = we_q && wa_q == rs2_addr && rs2_addr != '0;
        rs1_busy     = hit1 ? (issue_valid && issue_rd == rs1_addr) : busy_q[rs1_addr];
        rs2_busy     = hit2 ? (issue_valid && issue_rd == rs2_addr) : busy_q[rs2_addr];
        rs1_byp_data = hit1 ? wd_q : '0;
        rs2_byp_data = hit2 ? wd_q : '0;
    end
`else
    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];
`endif
endmodule
